// File: rtl/wash_pkg.sv
// wash_pkg
//   Shared definitions for the wash phase responder: the FSM state
//   encoding and the default phase durations. The durations are in clock cycles.
package wash_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5,
    FAULT = 3'd6
  } state_t;

  localparam int CNT_W_DEF        = 16;
  localparam int FILL_TIMEOUT_DEF = 64;
  localparam int WASH_CYCLES_DEF  = 200;
  localparam int RINSE_CYCLES_DEF = 100;
  localparam int DRAIN_CYCLES_DEF = 50;

endpackage

// File: rtl/wash_phase_responder_timer.sv
// phase_timer
//   Cycle counter for the timed wash phases.
//   Ports:
//     i_clk     clock, rising edge
//     i_reset   synchronous active-low reset, clears the count
//     i_clr     clear the count (state change); wins over i_en
//     i_en      count this cycle (timed state)
//     i_limit   phase length in cycles for the current state
//     o_cnt     cycles spent so far in the current state
//     o_expire  high on the last cycle of the phase (o_cnt == i_limit-1)
module phase_timer
  import wash_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_expire = (r_cnt == (i_limit - CNT_W'(1)));

endmodule

// File: rtl/wash_phase_responder.sv
// wash_phase_responder
//   Responder side of the controller's ready/done wash handshake. Latches the
//   loaded rack slots on acceptance, then sequences FILL -> WASH -> RINSE ->
//   DRAIN with timed phases and reports done (or fault on a fill timeout).
//   Ports:
//     i_clk          clock, rising edge
//     i_reset        synchronous active-low reset
//     i_ready        wash request level from the controller
//     i_slot_mask    loaded-slot flags, sampled on acceptance only
//     i_level_ok     tub-full sensor
//     o_out_slot     per-slot spray enables (WASH, RINSE)
//     o_fill_valve   FILL
//     o_heater       WASH
//     o_pump         WASH, RINSE
//     o_drain_valve  DRAIN, FAULT
//     o_busy         any state but IDLE
//     o_done         DONE
//     o_fault        FAULT
module wash_phase_responder
  import wash_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FILL_TIMEOUT = FILL_TIMEOUT_DEF,
  parameter int WASH_CYCLES  = WASH_CYCLES_DEF,
  parameter int RINSE_CYCLES = RINSE_CYCLES_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ready,
  input  logic [3:0] i_slot_mask,
  input  logic       i_level_ok,
  output logic [3:0] o_out_slot,
  output logic       o_fill_valve,
  output logic       o_heater,
  output logic       o_pump,
  output logic       o_drain_valve,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_fault
);

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_mask;
  logic [CNT_W-1:0] w_limit;
  logic             w_clr;
  logic             w_en;
  logic             w_expire;
  // The FSM only needs the expire flag; the raw count is left for observation.
  logic [CNT_W-1:0] w_cnt_unused;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && i_ready) begin
        r_mask <= i_slot_mask;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_ready) begin
          w_state_next = (i_slot_mask == 4'd0) ? DONE : FILL;
        end
      end
      FILL: begin
        // Abort first, then a full tub beats a simultaneous timeout.
        if (!i_ready)        w_state_next = DRAIN;
        else if (i_level_ok) w_state_next = WASH;
        else if (w_expire)   w_state_next = FAULT;
      end
      WASH: begin
        if (!i_ready)      w_state_next = DRAIN;
        else if (w_expire) w_state_next = RINSE;
      end
      RINSE: begin
        if (!i_ready || w_expire) w_state_next = DRAIN;
      end
      DRAIN: begin
        // Once draining, the phase always runs its full length.
        if (w_expire) w_state_next = DONE;
      end
      DONE, FAULT: begin
        if (!i_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_limit = '0;
    case (r_state)
      FILL:    w_limit = CNT_W'(FILL_TIMEOUT);
      WASH:    w_limit = CNT_W'(WASH_CYCLES);
      RINSE:   w_limit = CNT_W'(RINSE_CYCLES);
      DRAIN:   w_limit = CNT_W'(DRAIN_CYCLES);
      default: w_limit = '0;
    endcase
  end

  assign w_clr = (w_state_next != r_state);
  assign w_en  = (r_state == FILL) || (r_state == WASH) ||
                 (r_state == RINSE) || (r_state == DRAIN);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .i_limit  (w_limit),
    .o_cnt    (w_cnt_unused),
    .o_expire (w_expire)
  );

  assign o_out_slot    = (r_state == WASH || r_state == RINSE) ? r_mask : 4'd0;
  assign o_fill_valve  = (r_state == FILL);
  assign o_heater      = (r_state == WASH);
  assign o_pump        = (r_state == WASH) || (r_state == RINSE);
  assign o_drain_valve = (r_state == DRAIN) || (r_state == FAULT);
  assign o_busy        = (r_state != IDLE);
  assign o_done        = (r_state == DONE);
  assign o_fault       = (r_state == FAULT);

endmodule

// File: tb/tb_wash_phase_responder.sv
module tb_wash_phase_responder;

  localparam int FILL_T  = 64;
  localparam int WASH_C  = 200;
  localparam int RINSE_C = 100;
  localparam int DRAIN_C = 50;

  // Reference model phases (bench-local names).
  localparam int PH_IDLE  = 0;
  localparam int PH_FILL  = 1;
  localparam int PH_WASH  = 2;
  localparam int PH_RINSE = 3;
  localparam int PH_DRAIN = 4;
  localparam int PH_DONE  = 5;
  localparam int PH_FAULT = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ready;
  logic [3:0] slot_mask;
  logic       level_ok;
  logic [3:0] o_out_slot;
  logic       o_fill_valve, o_heater, o_pump, o_drain_valve, o_busy, o_done, o_fault;

  always #5 clk = ~clk;

  wash_phase_responder #(
    .CNT_W        (16),
    .FILL_TIMEOUT (FILL_T),
    .WASH_CYCLES  (WASH_C),
    .RINSE_CYCLES (RINSE_C),
    .DRAIN_CYCLES (DRAIN_C)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_ready       (ready),
    .i_slot_mask   (slot_mask),
    .i_level_ok    (level_ok),
    .o_out_slot    (o_out_slot),
    .o_fill_valve  (o_fill_valve),
    .o_heater      (o_heater),
    .o_pump        (o_pump),
    .o_drain_valve (o_drain_valve),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_fault       (o_fault)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: current phase, cycles remaining in that phase, latched mask.
  int         m_ph   = PH_IDLE;
  int         m_left = 0;
  logic [3:0] m_mask = 4'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [10:0] dut_outs();
    return {o_out_slot, o_fill_valve, o_heater, o_pump, o_drain_valve, o_busy, o_done, o_fault};
  endfunction

  function automatic logic [10:0] exp_outs();
    logic [3:0] sl;
    sl = (m_ph == PH_WASH || m_ph == PH_RINSE) ? m_mask : 4'd0;
    return {sl,
            1'(m_ph == PH_FILL),
            1'(m_ph == PH_WASH),
            1'(m_ph == PH_WASH || m_ph == PH_RINSE),
            1'(m_ph == PH_DRAIN || m_ph == PH_FAULT),
            1'(m_ph != PH_IDLE),
            1'(m_ph == PH_DONE),
            1'(m_ph == PH_FAULT)};
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    if (!rst_n) begin
      m_ph   = PH_IDLE;
      m_mask = 4'd0;
    end else begin
      case (m_ph)
        PH_IDLE: if (ready) begin
          m_mask = slot_mask;
          if (slot_mask == 4'd0) m_ph = PH_DONE;
          else begin m_ph = PH_FILL; m_left = FILL_T; end
        end
        PH_FILL: begin
          m_left--;
          if (!ready)            begin m_ph = PH_DRAIN; m_left = DRAIN_C; end
          else if (level_ok)     begin m_ph = PH_WASH;  m_left = WASH_C;  end
          else if (m_left == 0)  m_ph = PH_FAULT;
        end
        PH_WASH: begin
          m_left--;
          if (!ready)            begin m_ph = PH_DRAIN; m_left = DRAIN_C; end
          else if (m_left == 0)  begin m_ph = PH_RINSE; m_left = RINSE_C; end
        end
        PH_RINSE: begin
          m_left--;
          if (!ready || m_left == 0) begin m_ph = PH_DRAIN; m_left = DRAIN_C; end
        end
        PH_DRAIN: begin
          m_left--;
          if (m_left == 0) m_ph = PH_DONE;
        end
        default: if (!ready) m_ph = PH_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("outs", 32'(dut_outs()), 32'(exp_outs()));
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return o_fill_valve;
      1:       return o_heater;
      2:       return o_pump & ~o_heater;
      default: return o_drain_valve & ~o_fault;
    endcase
  endfunction

  // Count consecutive cycles a phase indicator stays high (bounded).
  task automatic count_while(input int which, output int n);
    n = 0;
    while (sel(which) && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (o_busy && k < 400) begin
      k++;
      tick();
    end
    check_eq(tag, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int n;
    int hold;
    int cyc;
    rst_n = 1'b0; ready = 1'b0; slot_mask = 4'd0; level_ok = 1'b0;
    tick(); tick();
    check_eq("rst_outs", 32'(dut_outs()), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: normal run
    slot_mask = 4'b1011; ready = 1'b1;
    tick();
    check_eq("accept_fill", 32'(o_fill_valve), 32'd1);
    repeat (5) tick();
    level_ok = 1'b1;
    tick();
    level_ok = 1'b0;
    check_eq("wash_slots", 32'(o_out_slot), 32'hB);
    count_while(1, n); check_eq("wash_len", n, WASH_C);
    count_while(2, n); check_eq("rinse_len", n, RINSE_C);
    count_while(3, n); check_eq("drain_len", n, DRAIN_C);
    check_eq("normal_done", 32'(o_done), 32'd1);
    ready = 1'b0;
    tick();
    check_eq("normal_idle", 32'(o_busy), 32'd0);
    $display("txn normal: mask=1011 done seen");

    // 2: fill timeout
    slot_mask = 4'b0101; ready = 1'b1;
    tick();
    count_while(0, n); check_eq("fill_timeout_len", n, FILL_T);
    check_eq("fault_flag", 32'(o_fault), 32'd1);
    check_eq("fault_drain", 32'(o_drain_valve), 32'd1);
    check_eq("fault_no_done", 32'(o_done), 32'd0);
    ready = 1'b0;
    tick();
    check_eq("fault_idle", 32'(o_busy), 32'd0);
    $display("txn timeout: fault after %0d fill cycles", n);

    // 3: abort at WASH cnt 20
    slot_mask = 4'b1110; ready = 1'b1;
    tick();
    level_ok = 1'b1;
    tick();
    level_ok = 1'b0;
    repeat (20) tick();
    ready = 1'b0;
    tick();
    check_eq("abort_slots", 32'(o_out_slot), 32'd0);
    count_while(3, n); check_eq("abort_drain_len", n, DRAIN_C);
    check_eq("abort_done", 32'(o_done), 32'd1);
    tick();
    check_eq("abort_idle", 32'(o_busy), 32'd0);
    $display("txn abort: drain %0d cycles", n);

    // 4: empty rack
    slot_mask = 4'b0000; ready = 1'b1;
    tick();
    check_eq("empty_done", 32'(o_done), 32'd1);
    check_eq("empty_act", 32'({o_out_slot, o_fill_valve, o_heater, o_pump, o_drain_valve}), 32'd0);
    ready = 1'b0;
    tick();
    $display("txn empty: done after accept");

    // 5: reset mid-RINSE, restart with ready held
    slot_mask = 4'b0110; ready = 1'b1;
    tick();
    level_ok = 1'b1;
    tick();
    level_ok = 1'b0;
    count_while(1, n);
    repeat (10) tick();
    check_eq("pre_rst_rinse", 32'(o_pump), 32'd1);
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_outs", 32'(dut_outs()), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("restart_fill", 32'(o_fill_valve), 32'd1);
    ready = 1'b0;
    wait_idle("rst_idle");
    $display("txn reset-mid-rinse: restarted fill");

    // 6: level_ok on the final FILL cycle, mask change during WASH
    slot_mask = 4'b1100; ready = 1'b1;
    tick();
    repeat (63) tick();
    level_ok = 1'b1;
    tick();
    level_ok = 1'b0;
    check_eq("late_level_wash", 32'(o_heater), 32'd1);
    check_eq("late_level_nofault", 32'(o_fault), 32'd0);
    slot_mask = 4'b0011;
    repeat (5) tick();
    check_eq("mask_held", 32'(o_out_slot), 32'hC);
    ready = 1'b0;
    wait_idle("simul_idle");
    $display("txn simultaneous: wash entered, mask held");

    // Randomized transactions against the model.
    for (int t = 0; t < 40; t++) begin
      slot_mask = 4'($urandom_range(0, 15));
      hold      = $urandom_range(1, 420);
      ready     = 1'b1;
      cyc       = 0;
      for (int c = 0; c < 800; c++) begin
        if (c >= hold || o_done || o_fault) ready = 1'b0;
        level_ok = ($urandom_range(0, 59) == 0);
        rst_n    = ($urandom_range(0, 499) != 0);
        tick();
        cyc++;
        if (!ready && !o_busy) break;
      end
      rst_n = 1'b1; ready = 1'b0; level_ok = 1'b0;
      wait_idle("rand_idle");
      $display("txn rand %0d: mask=%b hold=%0d cycles=%0d", t, slot_mask, hold, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
